// File: rtl/abc_pattern_sequencer.sv
// -----------------------------------------------------------------------------
// abc_pattern_sequencer
//
// Purpose:
//   Sequential stimulus source for the 3-input combinational lab stage. On a
//   start request it walks {a,b,c} through all eight patterns in a fixed
//   order. Step k is held for DWELL_BASE*(k+1) cycles, so an uninterrupted
//   sweep lasts DWELL_BASE*36 cycles. A one-cycle done pulse marks the end of
//   every sweep so a controller or checker can bracket it.
//
// Configuration macro:
//   SEQ_GRAY_EN  - when defined, patterns follow Gray order
//                  (000,001,011,010,110,111,101,100) so exactly one of a/b/c
//                  toggles per step. When undefined, patterns are the binary
//                  step index. Dwell timing is identical in both builds, and
//                  step_o always reports the binary index.
//
// Parameters:
//   DWELL_BASE - base dwell in cycles (>= 1)
//   CNT_W      - dwell counter width; 2**CNT_W must exceed 8*DWELL_BASE
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   synchronous active-low reset
//   start_i  in   level; starts a sweep when sampled high in IDLE
//   hold_i   in   pause; freezes counter, step and outputs while in RUN
//   a,b,c    out  pattern bits (a = MSB) to the lab stage
//   valid_o  out  high while a/b/c carry a sweep pattern
//   step_o   out  current binary step index 0..7
//   busy_o   out  high in RUN and DONE
//   done_o   out  one-cycle pulse when the sweep ends
//   state_o  out  FSM state for observation (0=IDLE, 1=RUN, 2=DONE)
//
// Handshake:
//   start_i is a level request. It is honoured only on an edge where the FSM
//   is in IDLE; in RUN or DONE it is ignored (no restart, no queuing). Once
//   accepted, busy_o rises with the first pattern and stays high through the
//   DONE cycle; done_o pulses for that single DONE cycle, and busy_o falls on
//   the following edge when the FSM returns to IDLE. The earliest restart is
//   therefore the edge after IDLE is re-entered.
//
// All outputs are registered; there is no combinational input-to-output path.
// -----------------------------------------------------------------------------
module abc_pattern_sequencer #(
  parameter int DWELL_BASE = 10,
  parameter int CNT_W      = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic       hold_i,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       valid_o,
  output logic [2:0] step_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [1:0] state_o
);

  // ---------------------------------------------------------------------------
  // FSM encoding
  // ---------------------------------------------------------------------------
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [2:0] LAST_STEP = 3'd7;

  // ---------------------------------------------------------------------------
  // Registered state
  // ---------------------------------------------------------------------------
  logic [1:0]       state_q, state_d;
  logic [2:0]       step_q,  step_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [2:0]       abc_q,   abc_d;
  logic             valid_q, valid_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;

  // ---------------------------------------------------------------------------
  // Pattern code for a step index. The Gray variant guarantees a single-bit
  // change at every step boundary, which keeps the lab stage from seeing
  // multi-input glitches while the sweep advances.
  // ---------------------------------------------------------------------------
  function automatic logic [2:0] step_code(input logic [2:0] k);
`ifdef SEQ_GRAY_EN
    return k ^ (k >> 1);
`else
    return k;
`endif
  endfunction

  // ---------------------------------------------------------------------------
  // Dwell bookkeeping
  //
  // The counter restarts at 0 on every step, so the terminal count for step k
  // is DWELL_BASE*(k+1)-1. The product is formed at 32 bits and then narrowed;
  // the CNT_W legality bound guarantees the largest value (8*DWELL_BASE-1)
  // fits in the counter.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] dwell_last;
  logic             dwell_end;
  logic [2:0]       step_inc;

  assign dwell_last = CNT_W'(DWELL_BASE * (32'(step_q) + 32'd1) - 1);
  assign dwell_end  = (cnt_q == dwell_last);
  assign step_inc   = step_q + 3'd1;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // Default: hold everything. done is a pulse, so it defaults low.
    state_d = state_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    abc_d   = abc_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_RUN;
          step_d  = 3'd0;
          cnt_d   = '0;
          abc_d   = step_code(3'd0);
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end

      ST_RUN: begin
        // hold_i freezes the whole datapath; because nothing moves, the dwell
        // resumes exactly where it stopped once hold_i drops.
        if (!hold_i) begin
          if (dwell_end) begin
            cnt_d = '0;
            if (step_q == LAST_STEP) begin
              // Sweep complete: blank the pattern and announce it.
              state_d = ST_DONE;
              step_d  = 3'd0;
              abc_d   = 3'b000;
              valid_d = 1'b0;
              done_d  = 1'b1;
            end else begin
              step_d = step_inc;
              abc_d  = step_code(step_inc);
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      ST_DONE: begin
        // Single-cycle state; start_i here is deliberately not sampled.
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        // Unreachable encoding: fall back to reset values.
        state_d = ST_IDLE;
        step_d  = 3'd0;
        cnt_d   = '0;
        abc_d   = 3'b000;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and output registers (synchronous active-low reset)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      step_q  <= 3'd0;
      cnt_q   <= '0;
      abc_q   <= 3'b000;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      abc_q   <= abc_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign a       = abc_q[2];
  assign b       = abc_q[1];
  assign c       = abc_q[0];
  assign valid_o = valid_q;
  assign step_o  = step_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_abc_pattern_sequencer.sv
// -----------------------------------------------------------------------------
// tb_abc_pattern_sequencer
//
// Self-checking bench for abc_pattern_sequencer (DWELL_BASE=10). Expected
// pattern segments {pattern, step, dwell length} are queued when a sweep is
// launched; a negedge monitor measures each segment the DUT produces and pops
// the matching expectation. Directed checks cover reset, sweep length, hold,
// ignored start and reset mid-run. Define SEQ_GRAY_EN to check the Gray build.
// -----------------------------------------------------------------------------
module tb_abc_pattern_sequencer;

  localparam int DWELL = 10;
  localparam int W     = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_i = 1'b0;
  logic       hold_i = 1'b0;
  logic       a, b, c;
  logic       valid_o;
  logic [2:0] step_o;
  logic       busy_o;
  logic       done_o;
  logic [1:0] state_o;

  always #5 clk = ~clk;

  abc_pattern_sequencer #(.DWELL_BASE(DWELL), .CNT_W(10)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start_i),
    .hold_i  (hold_i),
    .a       (a),
    .b       (b),
    .c       (c),
    .valid_o (valid_o),
    .step_o  (step_o),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .state_o (state_o)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [W-1:0] exp_q[$];   // {pattern[2:0], step[2:0], length[9:0]}
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int t0       = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic logic [2:0] pat(input int k);
`ifdef SEQ_GRAY_EN
    case (k)
      0: return 3'b000;
      1: return 3'b001;
      2: return 3'b011;
      3: return 3'b010;
      4: return 3'b110;
      5: return 3'b111;
      6: return 3'b101;
      default: return 3'b100;
    endcase
`else
    return 3'(k);
`endif
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push_sweep(input int nsteps, input int hold_step, input int extra);
    for (int k = 0; k < nsteps; k++) begin
      exp_q.push_back({pat(k), 3'(k), 10'(DWELL * (k + 1) + ((k == hold_step) ? extra : 0))});
    end
  endtask

  // Launch a sweep: the edge after start_i is raised is E0.
  task automatic start_sweep(input int nsteps, input int hold_step, input int extra,
                             input bit keep);
    push_sweep(nsteps, hold_step, extra);
    start_i = 1'b1;
    tick();
    t0 = cyc;
    if (!keep) start_i = 1'b0;
    check("start_valid", valid_o, 1);
    check("start_busy",  busy_o, 1);
    check("start_step",  step_o, 0);
    check("start_abc",   {a, b, c}, pat(0));
    check("start_state", state_o, ST_RUN);
  endtask

  task automatic run_to_done(input string tag, input int exp_len);
    while (!done_o && (cyc - t0) < 1000) tick();
    check(tag, cyc - t0, exp_len);
  endtask

  task automatic wait_step(input logic [2:0] s);
    int n;
    n = 0;
    while (step_o != s && n < 1000) begin
      tick();
      n++;
    end
    check("wait_step", step_o, s);
  endtask

  task automatic post_done();
    tick();
    check("post_done",  done_o, 0);
    check("post_busy",  busy_o, 0);
    check("post_valid", valid_o, 0);
    check("post_state", state_o, ST_IDLE);
    check("sb_empty",   exp_q.size(), 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_abc"},   {a, b, c}, 0);
    check({tag, "_valid"}, valid_o, 0);
    check({tag, "_busy"},  busy_o, 0);
    check({tag, "_done"},  done_o, 0);
    check({tag, "_step"},  step_o, 0);
    check({tag, "_state"}, state_o, ST_IDLE);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: measures each contiguous valid segment of one step
  // ---------------------------------------------------------------------------
  logic       seg_active = 1'b0;
  logic       seg_glitch = 1'b0;
  logic [2:0] seg_step = 3'd0;
  logic [2:0] seg_pat = 3'd0;
  int         seg_len = 0;

  always @(negedge clk) begin
    logic [W-1:0] e;
    logic         ended;
    logic [2:0]   cur;
    cur   = {a, b, c};
    ended = 1'b0;
    if (!rst_n) begin
      seg_active = 1'b0;   // interrupted segment is abandoned
    end else begin
      if (seg_active && (!valid_o || step_o != seg_step)) begin
        ended = 1'b1;
        if (exp_q.size() == 0) begin
          check("seg_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("seg_pat",    seg_pat, e[15:13]);
          check("seg_step",   seg_step, e[12:10]);
          check("seg_len",    seg_len, e[9:0]);
          check("seg_stable", seg_glitch, 0);
        end
        seg_active = 1'b0;
      end
      if (valid_o && !seg_active) begin
`ifdef SEQ_GRAY_EN
        if (ended) check("gray_hamming", $countones(cur ^ seg_pat), 1);
`endif
        seg_active = 1'b1;
        seg_step   = step_o;
        seg_pat    = cur;
        seg_len    = 1;
        seg_glitch = 1'b0;
      end else if (seg_active) begin
        seg_len++;
        if (cur != seg_pat) seg_glitch = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    // Reset held for 3 cycles
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check_reset_vals("reset");

    // Idle stays idle with start low; hold has no effect in IDLE
    hold_i = 1'b1;
    repeat ($urandom_range(3, 8)) tick();
    hold_i = 1'b0;
    check("idle_state", state_o, ST_IDLE);
    check("idle_busy",  busy_o, 0);

    // Full sweep, no holds
    start_sweep(8, -1, 0, 1'b0);
    run_to_done("sweep_len", 360);
    post_done();

    // Hold for 15 cycles inside step 3
    start_sweep(8, 3, 15, 1'b0);
    wait_step(3'd3);
    repeat ($urandom_range(2, 20)) tick();
    hold_i = 1'b1;
    repeat (15) tick();
    check("hold_step", step_o, 3);
    hold_i = 1'b0;
    run_to_done("hold_len", 375);
    post_done();

    // start held high throughout: one done per sweep, restart only from IDLE
    start_sweep(8, -1, 0, 1'b1);
    run_to_done("cont_len", 360);
    tick();   // edge leaving DONE: start must not be honoured here
    check("cont_idle_state", state_o, ST_IDLE);
    check("cont_idle_busy",  busy_o, 0);
    check("cont_sb_empty",   exp_q.size(), 0);
    push_sweep(8, -1, 0);
    tick();   // start sampled in IDLE
    t0 = cyc;
    start_i = 1'b0;
    check("restart_busy", busy_o, 1);
    check("restart_step", step_o, 0);
    run_to_done("restart_len", 360);
    post_done();

    // Reset during step 5, then a fresh full sweep
    start_sweep(5, -1, 0, 1'b0);
    wait_step(3'd5);
    repeat ($urandom_range(1, 40)) tick();
    rst_n = 1'b0;
    tick();
    check_reset_vals("midrst");
    rst_n = 1'b1;
    tick();
    check("midrst_sb_empty", exp_q.size(), 0);
    start_sweep(8, -1, 0, 1'b0);
    run_to_done("after_rst_len", 360);
    post_done();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
